// File: rtl/rx_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module   : rx_stream_checker
//  Purpose  : Drains the RX FIFO, checks for an incrementing byte stream and
//             writes a 9-byte result report into the TX FIFO.
//  Revision : 1.0
// ============================================================================
module rx_stream_checker #(
    parameter int          DATA_W           = 8,
    parameter int unsigned TEST_WORDS_TOTAL = 1024,
    parameter int unsigned TIMEOUT_CYCLES   = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rxfifo_rd,
    input  logic [DATA_W-1:0] rxfifo_data,
    input  logic              rxfifo_valid,
    input  logic              rxfifo_empty,
    output logic [7:0]        txfifo_data,
    output logic              txfifo_wr,
    input  logic              txfifo_full,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    localparam logic [31:0]       c_total   = 32'(TEST_WORDS_TOTAL);
    localparam logic [31:0]       c_timeout = 32'(TIMEOUT_CYCLES);
    localparam logic [DATA_W-1:0] c_one     = DATA_W'(1);

    state_t              r_state;
    logic [31:0]         r_rd_cnt;
    logic [31:0]         r_rx_cnt;
    logic [31:0]         r_err_cnt;
    logic [31:0]         r_to_cnt;
    logic [DATA_W-1:0]   r_expected;
    logic                r_timeout;
    logic                r_pass;
    logic                r_busy;
    logic                r_done;
    logic [3:0]          r_byte_idx;

    logic                w_active;
    logic                w_beat;
    logic                w_mismatch;
    logic [31:0]         w_rx_nxt;
    logic [31:0]         w_err_nxt;
    logic [31:0]         w_to_inc;
    logic                w_to_hit;
    logic                w_rx_done;
    logic                w_go_report;

    assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_beat      = w_active && rxfifo_valid;
    assign w_mismatch  = (rxfifo_data != r_expected);
    assign w_rx_nxt    = w_beat ? (r_rx_cnt + 32'd1) : r_rx_cnt;
    assign w_err_nxt   = (w_beat && w_mismatch && (r_err_cnt != 32'hFFFF_FFFF))
                         ? (r_err_cnt + 32'd1) : r_err_cnt;
    assign w_to_inc    = r_to_cnt + 32'd1;
    assign w_to_hit    = w_active && !rxfifo_valid && (w_to_inc == c_timeout);
    assign w_rx_done   = (r_state == S_DRAIN) && (w_rx_nxt == c_total);
    assign w_go_report = w_to_hit || w_rx_done;

    assign rxfifo_rd = (r_state == S_RUN) && !rxfifo_empty && (r_rd_cnt < c_total);
    assign txfifo_wr = (r_state == S_REPORT) && !txfifo_full;

    // Report layout: status, err_cnt LE, rx_cnt LE
    always_comb begin
        txfifo_data = 8'h00;
        if (r_state == S_REPORT) begin
            case (r_byte_idx)
                4'd0:    txfifo_data = {6'b0, r_timeout, r_pass};
                4'd1:    txfifo_data = r_err_cnt[7:0];
                4'd2:    txfifo_data = r_err_cnt[15:8];
                4'd3:    txfifo_data = r_err_cnt[23:16];
                4'd4:    txfifo_data = r_err_cnt[31:24];
                4'd5:    txfifo_data = r_rx_cnt[7:0];
                4'd6:    txfifo_data = r_rx_cnt[15:8];
                4'd7:    txfifo_data = r_rx_cnt[23:16];
                4'd8:    txfifo_data = r_rx_cnt[31:24];
                default: txfifo_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rd_cnt   <= 32'd0;
            r_rx_cnt   <= 32'd0;
            r_err_cnt  <= 32'd0;
            r_to_cnt   <= 32'd0;
            r_expected <= '0;
            r_timeout  <= 1'b0;
            r_pass     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_byte_idx <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_rd_cnt   <= 32'd0;
                        r_rx_cnt   <= 32'd0;
                        r_err_cnt  <= 32'd0;
                        r_to_cnt   <= 32'd0;
                        r_expected <= '0;
                        r_timeout  <= 1'b0;
                        r_pass     <= 1'b0;
                        r_byte_idx <= 4'd0;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (rxfifo_rd) begin
                        r_rd_cnt <= r_rd_cnt + 32'd1;
                    end
                    if (w_beat) begin
                        r_rx_cnt  <= w_rx_nxt;
                        r_err_cnt <= w_err_nxt;
                        r_to_cnt  <= 32'd0;
                        // Resync on mismatch so a dropped word costs one error
                        r_expected <= w_mismatch ? (rxfifo_data + c_one) : (r_expected + c_one);
                    end else begin
                        r_to_cnt <= w_to_inc;
                    end
                    if (w_go_report) begin
                        r_state    <= S_REPORT;
                        r_timeout  <= w_to_hit;
                        r_pass     <= (w_err_nxt == 32'd0) && !w_to_hit && (w_rx_nxt == c_total);
                        r_byte_idx <= 4'd0;
                    end else if ((r_state == S_RUN) && rxfifo_rd && ((r_rd_cnt + 32'd1) == c_total)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_REPORT: begin
                    if (txfifo_wr) begin
                        if (r_byte_idx == 4'd8) begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_byte_idx <= 4'd0;
                        end else begin
                            r_byte_idx <= r_byte_idx + 4'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire
